// File: rtl/spio_hss_multiplexer_pkt_serializer_pkg.sv
// ============================================================================
// Module  : spio_hss_multiplexer_pkt_serializer_pkg
// Brief   : Types and helpers shared by the packet serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spio_hss_multiplexer_pkt_serializer_pkg;

    localparam int c_PKT_BITS            = 72;
    localparam int c_PKT_HDR_LSB         = 0;
    localparam int c_PKT_KEY_MSB         = 39;
    localparam int c_PKT_PLD_LSB         = 40;
    localparam int c_PKT_PLD_MSB         = 71;
    localparam int c_PKT_PLD_PRESENT_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        PLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pld;
        logic [31:0] key;
        logic [7:0]  hdr;
    } pkt_t;

    function automatic logic has_payload(input logic [7:0] hdr);
        return hdr[c_PKT_PLD_PRESENT_BIT];
    endfunction

endpackage

`default_nettype wire

// File: rtl/spio_hss_multiplexer_pkt_parity.sv
// ============================================================================
// Module  : spio_hss_multiplexer_pkt_parity
// Brief   : Odd-parity check over hdr+key, or hdr+key+payload for long packets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spio_hss_multiplexer_pkt_parity
    import spio_hss_multiplexer_pkt_serializer_pkg::*;
(
    input  logic [c_PKT_BITS-1:0] pkt,
    output logic                  parity_ok
);

    logic w_hdr_key_par;
    logic w_pld_par;
    logic w_long;

    assign w_hdr_key_par = ^pkt[c_PKT_KEY_MSB:c_PKT_HDR_LSB];
    assign w_pld_par     = ^pkt[c_PKT_PLD_MSB:c_PKT_PLD_LSB];
    assign w_long        = pkt[c_PKT_HDR_LSB + c_PKT_PLD_PRESENT_BIT];

    assign parity_ok = w_long ? (w_hdr_key_par ^ w_pld_par) : w_hdr_key_par;

endmodule

`default_nettype wire

// File: rtl/spio_hss_multiplexer_pkt_serializer.sv
// ============================================================================
// Module  : spio_hss_multiplexer_pkt_serializer
// Brief   : Splits 72-bit packets into key / payload words with valid-ready.
//           Define PKT_SERIALIZER_PARITY_CHK_EN to drop and count bad packets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spio_hss_multiplexer_pkt_serializer
    import spio_hss_multiplexer_pkt_serializer_pkg::*;
#(
    parameter int ERR_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [c_PKT_BITS-1:0] pkt_data,
    input  logic                  pkt_vld,
    output logic                  pkt_rdy,
    output logic [31:0]           wrd_data,
    output logic [7:0]            wrd_hdr,
    output logic                  wrd_last,
    output logic                  wrd_vld,
    input  logic                  wrd_rdy,
    output logic [ERR_BITS-1:0]   err_cnt
);

    state_t      r_state;
    logic [31:0] r_pld;

    pkt_t w_pkt;
    logic w_pkt_ok;
    logic w_handoff_last;
    logic w_accept;
    logic w_load;

    assign w_pkt          = pkt_t'(pkt_data);
    assign w_handoff_last = wrd_vld && wrd_rdy && wrd_last;
    assign pkt_rdy        = (r_state == IDLE) || w_handoff_last;
    assign w_accept       = pkt_vld && pkt_rdy;
    assign w_load         = w_accept && w_pkt_ok;

`ifdef PKT_SERIALIZER_PARITY_CHK_EN
    spio_hss_multiplexer_pkt_parity u_parity (
        .pkt       (pkt_data),
        .parity_ok (w_pkt_ok)
    );

    // Bad packets are consumed but never reach the word side; count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (w_accept && !w_pkt_ok && (err_cnt != {ERR_BITS{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign w_pkt_ok = 1'b1;
    assign err_cnt  = '0;
`endif

    // Loading takes priority: pkt_rdy is only high in IDLE or on a final
    // handoff, so a new packet always replaces a finished one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pld    <= '0;
            wrd_vld  <= 1'b0;
            wrd_last <= 1'b0;
            wrd_data <= '0;
            wrd_hdr  <= '0;
        end else if (w_load) begin
            r_state  <= KEY;
            r_pld    <= w_pkt.pld;
            wrd_vld  <= 1'b1;
            wrd_last <= !has_payload(w_pkt.hdr);
            wrd_data <= w_pkt.key;
            wrd_hdr  <= w_pkt.hdr;
        end else if ((r_state == KEY) && wrd_rdy && !wrd_last) begin
            r_state  <= PLD;
            wrd_last <= 1'b1;
            wrd_data <= r_pld;
        end else if (w_handoff_last) begin
            r_state  <= IDLE;
            wrd_vld  <= 1'b0;
            wrd_last <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_pkt_serializer.sv
// ============================================================================
// Module  : tb_spio_hss_multiplexer_pkt_serializer
// Brief   : Directed self-checking bench for the packet serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spio_hss_multiplexer_pkt_serializer;

    logic        clk;
    logic        rst;
    logic [71:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_rdy;
    logic [31:0] wrd_data;
    logic [7:0]  wrd_hdr;
    logic        wrd_last;
    logic        wrd_vld;
    logic        wrd_rdy;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int pkts_out = 0;

    spio_hss_multiplexer_pkt_serializer #(.ERR_BITS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .pkt_data (pkt_data),
        .pkt_vld  (pkt_vld),
        .pkt_rdy  (pkt_rdy),
        .wrd_data (wrd_data),
        .wrd_hdr  (wrd_hdr),
        .wrd_last (wrd_last),
        .wrd_vld  (wrd_vld),
        .wrd_rdy  (wrd_rdy),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && wrd_vld && wrd_rdy && wrd_last) pkts_out <= pkts_out + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [7:0] h,
                            input logic l);
        chk({tag, "_vld"},  64'(wrd_vld),  64'd1);
        chk({tag, "_data"}, 64'(wrd_data), 64'(d));
        chk({tag, "_hdr"},  64'(wrd_hdr),  64'(h));
        chk({tag, "_last"}, 64'(wrd_last), 64'(l));
    endtask

    function automatic logic [71:0] mk(input logic [7:0] h, input logic [31:0] k,
                                       input logic [31:0] p);
        return {p, k, h};
    endfunction

`ifdef PKT_SERIALIZER_PARITY_CHK_EN
    task automatic send(input logic [71:0] p);
        int n;
        pkt_data = p;
        pkt_vld  = 1'b1;
        n = 0;
        #1;
        while (!pkt_rdy && n < 20) begin
            tick();
            n++;
        end
        chk("send_rdy", 64'(pkt_rdy), 64'd1);
        tick();
        pkt_vld = 1'b0;
    endtask
`endif

    initial begin
        int base;
        rst      = 1'b1;
        pkt_vld  = 1'b0;
        pkt_data = '0;
        wrd_rdy  = 1'b0;
        tick();
        tick();
        chk("rst_vld",  64'(wrd_vld),  64'd0);
        chk("rst_last", 64'(wrd_last), 64'd0);
        chk("rst_data", 64'(wrd_data), 64'd0);
        chk("rst_hdr",  64'(wrd_hdr),  64'd0);
        chk("rst_err",  64'(err_cnt),  64'd0);
        chk("rst_rdy",  64'(pkt_rdy),  64'd1);
        rst = 1'b0;
        tick();

        // Short packet
        wrd_rdy  = 1'b1;
        pkt_data = mk(8'h00, 32'hDEADBEEF, 32'h0);
        pkt_vld  = 1'b1;
        #1;
        chk("short_acc_rdy", 64'(pkt_rdy), 64'd1);
        tick();
        pkt_vld = 1'b0;
        #1;
        chk_word("short_w0", 32'hDEADBEEF, 8'h00, 1'b1);
        tick();
        chk("short_done_vld", 64'(wrd_vld), 64'd0);

        // Long packet, consecutive words
        pkt_data = mk(8'h02, 32'h12345678, 32'hCAFEF00D);
        pkt_vld  = 1'b1;
        tick();
        pkt_vld = 1'b0;
        #1;
        chk_word("long_w0", 32'h12345678, 8'h02, 1'b0);
        chk("long_w0_rdy", 64'(pkt_rdy), 64'd0);
        tick();
        chk_word("long_w1", 32'hCAFEF00D, 8'h02, 1'b1);
        chk("long_w1_rdy", 64'(pkt_rdy), 64'd1);
        tick();
        chk("long_done_vld", 64'(wrd_vld), 64'd0);

        // Long packet with back-pressure; a short packet waits behind it
        wrd_rdy  = 1'b0;
        pkt_data = mk(8'h06, 32'h0BADC0DE, 32'h55AA33CC);
        pkt_vld  = 1'b1;
        tick();
        pkt_data = mk(8'h10, 32'hA5A5A5A5, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_word("bp_key", 32'h0BADC0DE, 8'h06, 1'b0);
            chk("bp_key_rdy", 64'(pkt_rdy), 64'd0);
            tick();
        end
        wrd_rdy = 1'b1;
        #1;
        chk("bp_key_hs_rdy", 64'(pkt_rdy), 64'd0);
        tick();
        wrd_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_word("bp_pld", 32'h55AA33CC, 8'h06, 1'b1);
            chk("bp_pld_rdy", 64'(pkt_rdy), 64'd0);
            tick();
        end
        wrd_rdy = 1'b1;
        #1;
        chk("bp_pld_hs_rdy", 64'(pkt_rdy), 64'd1);
        tick();
        pkt_vld = 1'b0;
        #1;
        chk_word("bp_next", 32'hA5A5A5A5, 8'h10, 1'b1);
        tick();
        chk("bp_done_vld", 64'(wrd_vld), 64'd0);

        // Ten back-to-back short packets
        base = pkts_out;
        for (int i = 0; i < 10; i++) begin
            pkt_data = mk(8'((i % 16) << 4), 32'h1000 + 32'(i), 32'h0);
            pkt_vld  = 1'b1;
            #1;
            chk("b2b_rdy", 64'(pkt_rdy), 64'd1);
            if (i > 0) chk_word("b2b_w", 32'h1000 + 32'(i - 1), 8'(((i - 1) % 16) << 4), 1'b1);
            tick();
        end
        pkt_vld = 1'b0;
        #1;
        chk_word("b2b_w9", 32'h1009, 8'h90, 1'b1);
        tick();
        chk("b2b_done_vld", 64'(wrd_vld), 64'd0);
        chk("b2b_count", 64'(pkts_out - base), 64'd10);

        // Reset while waiting in the payload phase
        wrd_rdy  = 1'b0;
        pkt_data = mk(8'h02, 32'h11112222, 32'h33334444);
        pkt_vld  = 1'b1;
        tick();
        pkt_vld = 1'b0;
        wrd_rdy = 1'b1;
        tick();
        wrd_rdy = 1'b0;
        #1;
        chk_word("rstm_pld", 32'h33334444, 8'h02, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstm_vld",  64'(wrd_vld),  64'd0);
        chk("rstm_last", 64'(wrd_last), 64'd0);
        chk("rstm_data", 64'(wrd_data), 64'd0);
        chk("rstm_idle", 64'(pkt_rdy),  64'd1);
        chk("rstm_err",  64'(err_cnt),  64'd0);
        rst     = 1'b0;
        wrd_rdy = 1'b1;
        tick();
        tick();
        chk("rstm_after_vld", 64'(wrd_vld), 64'd0);

`ifdef PKT_SERIALIZER_PARITY_CHK_EN
        base = pkts_out;
        send(mk(8'h00, 32'h00000000, 32'h0));
        send(mk(8'h01, 32'h00000000, 32'h0));
        send(mk(8'h02, 32'h00000000, 32'h1));
        send(mk(8'h02, 32'h00000000, 32'h0));
        send(mk(8'h00, 32'h00000003, 32'h0));
        for (int i = 0; i < 4; i++) tick();
        chk("par_err_cnt", 64'(err_cnt), 64'd3);
        chk("par_pkts", 64'(pkts_out - base), 64'd2);
        chk("par_idle", 64'(wrd_vld), 64'd0);
`else
        chk("nopar_err_cnt", 64'(err_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
